// File: rtl/baud_pkg.sv
// Shared definitions for the baud-rate controller.
// Holds the rate codes, the 16x divisor table and the controller FSM state encoding.
// Used by baud_ctrl and baud_tick_gen through import baud_pkg::*.
package baud_pkg;

    typedef enum logic [1:0] {
        Rate2400  = 2'b00,
        Rate4800  = 2'b01,
        Rate9600  = 2'b10,
        Rate19200 = 2'b11
    } rate_e;

    typedef enum logic [1:0] {
        StRun   = 2'b00,
        StDrain = 2'b01,
        StLoad  = 2'b10
    } state_e;

    // 50 MHz / (16 * baud), rounded to the nearest integer
    localparam int unsigned DIV_2400  = 1302;
    localparam int unsigned DIV_4800  = 651;
    localparam int unsigned DIV_9600  = 326;
    localparam int unsigned DIV_19200 = 163;

    function automatic int unsigned rate_div(input logic [1:0] rate);
        int unsigned div;
        div = DIV_9600;
        unique case (rate)
            Rate2400:  div = DIV_2400;
            Rate4800:  div = DIV_4800;
            Rate9600:  div = DIV_9600;
            Rate19200: div = DIV_19200;
            default:   div = DIV_9600;
        endcase
        return div;
    endfunction

endpackage

// File: rtl/baud_tick_gen.sv
// 16x divider and bit-phase counter.
// Ports:
//   clock, reset - system clock, asynchronous active-high reset
//   div          - divisor for the active rate (tick16 period in cycles)
//   clear        - synchronously zero both counters and suppress output pulses
//   tick16       - one-cycle pulse every div cycles
//   bit_tick     - one-cycle pulse on every 16th tick16 (phase wrap 15 -> 0)
module baud_tick_gen
    import baud_pkg::*;
#(
    parameter int unsigned CNT_W = 11
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [CNT_W-1:0] div,
    input  logic             clear,
    output logic             tick16,
    output logic             bit_tick
);

    logic [CNT_W-1:0] div_cnt_q, div_cnt_d;
    logic [3:0]       phase_q, phase_d;
    logic             at_end;

    always_comb begin
        at_end    = (div_cnt_q == div - CNT_W'(1));
        tick16    = at_end && !clear;
        bit_tick  = tick16 && (phase_q == 4'd15);
        div_cnt_d = div_cnt_q + CNT_W'(1);
        phase_d   = phase_q;
        if (clear) begin
            div_cnt_d = '0;
            phase_d   = '0;
        end else if (at_end) begin
            div_cnt_d = '0;
            phase_d   = phase_q + 4'd1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            div_cnt_q <= '0;
            phase_q   <= '0;
        end else begin
            div_cnt_q <= div_cnt_d;
            phase_q   <= phase_d;
        end
    end

endmodule

// File: rtl/baud_ctrl.sv
// Baud-rate controller: generates 16x and bit ticks and switches rate only between frames.
// A rate request is accepted in RUN, then the FSM waits in DRAIN (old rate still ticking)
// until both serial units are idle, and spends one LOAD cycle installing the new rate and
// restarting the tick phase.
// Ports:
//   clock, reset         - system clock, asynchronous active-high reset
//   cfg_valid/cfg_rate   - rate-change request; cfg_ready high only in RUN
//   tx_busy, rx_busy     - serial units are mid-frame
//   tick16, bit_tick     - rate pulses
//   active_rate          - rate code in use
//   switching            - high while not in RUN
//   timeout              - sticky, set when a drain was forced
// Optional feature: define BAUD_CTRL_TIMEOUT_EN to force LOAD after TIMEOUT_BITS bit_ticks in
// DRAIN; without it DRAIN waits indefinitely and timeout is tied low.
module baud_ctrl
    import baud_pkg::*;
#(
    parameter int unsigned CNT_W        = 11,
    parameter logic [1:0]  RESET_RATE   = 2'b10,
    parameter int unsigned TIMEOUT_BITS = 32
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       cfg_valid,
    input  logic [1:0] cfg_rate,
    output logic       cfg_ready,
    input  logic       tx_busy,
    input  logic       rx_busy,
    output logic       tick16,
    output logic       bit_tick,
    output logic [1:0] active_rate,
    output logic       switching,
    output logic       timeout
);

    state_e           state_q, state_d;
    logic [1:0]       active_rate_q, active_rate_d;
    logic [1:0]       pending_rate_q, pending_rate_d;
    logic             clear;
    logic [CNT_W-1:0] div_val;

`ifdef BAUD_CTRL_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT_BITS + 1);
    logic [TO_W-1:0] drain_bits_q, drain_bits_d;
    logic            timeout_q, timeout_d;
`else
    // Parameter only matters when the drain timeout is built in
    logic unused_timeout_bits;
    assign unused_timeout_bits = |TIMEOUT_BITS;
`endif

    assign div_val = CNT_W'(rate_div(active_rate_q));

    baud_tick_gen #(
        .CNT_W (CNT_W)
    ) u_tick_gen (
        .clock    (clock),
        .reset    (reset),
        .div      (div_val),
        .clear    (clear),
        .tick16   (tick16),
        .bit_tick (bit_tick)
    );

    always_comb begin
        state_d        = state_q;
        active_rate_d  = active_rate_q;
        pending_rate_d = pending_rate_q;
        cfg_ready      = 1'b0;
        clear          = 1'b0;
`ifdef BAUD_CTRL_TIMEOUT_EN
        drain_bits_d   = drain_bits_q;
        timeout_d      = timeout_q;
`endif
        unique case (state_q)
            StRun: begin
                cfg_ready = 1'b1;
                if (cfg_valid) begin
                    pending_rate_d = cfg_rate;
                    state_d        = StDrain;
`ifdef BAUD_CTRL_TIMEOUT_EN
                    drain_bits_d   = '0;
`endif
                end
            end
            StDrain: begin
                // Ticks keep running at the old rate until both units are between frames
                if (!tx_busy && !rx_busy) begin
                    state_d = StLoad;
                end
`ifdef BAUD_CTRL_TIMEOUT_EN
                else if (bit_tick) begin
                    if (drain_bits_q == TO_W'(TIMEOUT_BITS - 1)) begin
                        state_d   = StLoad;
                        timeout_d = 1'b1;
                    end
                    drain_bits_d = drain_bits_q + TO_W'(1);
                end
`endif
            end
            StLoad: begin
                active_rate_d = pending_rate_q;
                clear         = 1'b1;
                state_d       = StRun;
            end
            default: state_d = StRun;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q        <= StRun;
            active_rate_q  <= RESET_RATE;
            pending_rate_q <= RESET_RATE;
        end else begin
            state_q        <= state_d;
            active_rate_q  <= active_rate_d;
            pending_rate_q <= pending_rate_d;
        end
    end

`ifdef BAUD_CTRL_TIMEOUT_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            drain_bits_q <= '0;
            timeout_q    <= 1'b0;
        end else begin
            drain_bits_q <= drain_bits_d;
            timeout_q    <= timeout_d;
        end
    end
    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif

    assign active_rate = active_rate_q;
    assign switching   = (state_q != StRun);

endmodule

// File: tb/tb_baud_ctrl.sv
// Directed bench for baud_ctrl with a cycle-level reference model.
module tb_baud_ctrl;

`ifdef BAUD_CTRL_TIMEOUT_EN
    // Short drain timeout so the forced drain fits the cycle budget
    localparam int unsigned TB_TO = 4;
`else
    localparam int unsigned TB_TO = 32;
`endif

    logic       clock = 1'b0;
    logic       reset;
    logic       cfg_valid;
    logic [1:0] cfg_rate;
    logic       cfg_ready;
    logic       tx_busy;
    logic       rx_busy;
    logic       tick16;
    logic       bit_tick;
    logic [1:0] active_rate;
    logic       switching;
    logic       timeout;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    bit chk_en = 1'b0;

    baud_ctrl #(
        .CNT_W        (11),
        .RESET_RATE   (2'b10),
        .TIMEOUT_BITS (TB_TO)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .cfg_valid   (cfg_valid),
        .cfg_rate    (cfg_rate),
        .cfg_ready   (cfg_ready),
        .tx_busy     (tx_busy),
        .rx_busy     (rx_busy),
        .tick16      (tick16),
        .bit_tick    (bit_tick),
        .active_rate (active_rate),
        .switching   (switching),
        .timeout     (timeout)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // Reference model: m_e counts edges since the last phase restart (reset or LOAD);
    // the tick pattern follows from plain modular arithmetic on it.
    int         div_tab [4] = '{1302, 651, 326, 163};
    logic [1:0] m_rate, m_pend;
    bit         m_drain, m_load, m_to;
    int         m_e;
`ifdef BAUD_CTRL_TIMEOUT_EN
    int         m_bits;
`endif

    function automatic bit exp_tick();
        int d;
        d = div_tab[m_rate];
        return !m_load && ((m_e % d) == d - 1);
    endfunction

    function automatic bit exp_bit();
        int d;
        d = div_tab[m_rate];
        return exp_tick() && (((m_e / d) % 16) == 15);
    endfunction

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_rate  <= 2'b10;
            m_pend  <= 2'b10;
            m_drain <= 1'b0;
            m_load  <= 1'b0;
            m_to    <= 1'b0;
            m_e     <= 0;
`ifdef BAUD_CTRL_TIMEOUT_EN
            m_bits  <= 0;
`endif
        end else if (m_load) begin
            m_rate <= m_pend;
            m_load <= 1'b0;
            m_e    <= 0;
        end else begin
            m_e <= m_e + 1;
            if (m_drain) begin
                if (!tx_busy && !rx_busy) begin
                    m_drain <= 1'b0;
                    m_load  <= 1'b1;
                end
`ifdef BAUD_CTRL_TIMEOUT_EN
                else if (exp_bit()) begin
                    if (m_bits + 1 == TB_TO) begin
                        m_drain <= 1'b0;
                        m_load  <= 1'b1;
                        m_to    <= 1'b1;
                    end
                    m_bits <= m_bits + 1;
                end
`endif
            end else if (cfg_valid) begin
                m_pend  <= cfg_rate;
                m_drain <= 1'b1;
`ifdef BAUD_CTRL_TIMEOUT_EN
                m_bits  <= 0;
`endif
            end
        end
    end

    always @(negedge clock) begin : cmp
        logic [6:0] got, want;
        if (chk_en) begin
            got  = {tick16, bit_tick, active_rate, switching, cfg_ready, timeout};
            want = {exp_tick(), exp_bit(), m_rate, m_drain || m_load,
                    !(m_drain || m_load), m_to};
            n_vec++;
            if (got !== want) begin
                n_err++;
                $display("FAIL cycle %0d {tick16,bit_tick,rate,switching,ready,timeout}: got %b want %b",
                         cyc, got, want);
            end
        end
    end

    task automatic check(input string name, input int got, input int want);
        n_vec++;
        if (got != want) begin
            n_err++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    // Wait (bounded) for tick16 or bit_tick at a negedge; returns the cycle number
    task automatic wait_for(input bit want_bit, input int budget, input string what,
                            output int at);
        at = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clock);
            if (want_bit ? bit_tick : tick16) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) begin
            n_vec++;
            n_err++;
            $display("FAIL %s: no pulse within %0d cycles, want one", what, budget);
        end
    endtask

    // Present a request for one cycle; returns at the negedge where DRAIN is visible
    task automatic request(input logic [1:0] r);
        cfg_rate  = r;
        cfg_valid = 1'b1;
        @(negedge clock);
        cfg_valid = 1'b0;
    endtask

    initial begin : watchdog
        #1500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int rel, t0, t1, b0, b1, s, ld, nb;
        bit done;
        reset = 1'b1; cfg_valid = 1'b0; cfg_rate = 2'b00; tx_busy = 1'b0; rx_busy = 1'b0;
        chk_en = 1'b1;
        repeat (3) @(negedge clock);
        check("reset active_rate", int'(active_rate), 2);
        check("reset switching", int'(switching), 0);
        check("reset cfg_ready", int'(cfg_ready), 1);
        check("reset tick16", int'(tick16), 0);
        check("reset timeout", int'(timeout), 0);
        #2 reset = 1'b0;
        rel = cyc;

        // Reset release at 9600: tick16 every 326, bit_tick every 5216
        wait_for(1'b0, 400, "t1 first tick16", t0);
        check("t1 first tick16 offset", t0 - rel, 325);
        wait_for(1'b0, 400, "t1 second tick16", t1);
        check("t1 tick16 period", t1 - t0, 326);
        wait_for(1'b1, 5300, "t1 first bit_tick", b0);
        check("t1 first bit_tick offset", b0 - rel, 5215);
        wait_for(1'b1, 5300, "t1 second bit_tick", b1);
        check("t1 bit_tick period", b1 - b0, 5216);

        // Request 2400 while tx busy for 4000 cycles: old period until busy falls
        tx_busy = 1'b1;
        s = cyc;
        request(2'b00);
        check("t3 in drain", int'(switching), 1);
        wait_for(1'b0, 400, "t3 drain tick a", t0);
        wait_for(1'b0, 400, "t3 drain tick b", t1);
        check("t3 drain tick16 period", t1 - t0, 326);
        while (cyc - s < 4000) @(negedge clock);
        check("t3 still draining", int'(switching), 1);
        check("t3 old rate kept", int'(active_rate), 2);
        tx_busy = 1'b0;
        @(negedge clock);
        ld = cyc;
        check("t3 load switching", int'(switching), 1);
        check("t3 load tick16 low", int'(tick16), 0);
        @(negedge clock);
        check("t3 back in run", int'(switching), 0);
        check("t3 new rate", int'(active_rate), 0);
        wait_for(1'b0, 1400, "t3 first new tick", t0);
        check("t3 first tick after load", t0 - ld, 1302);
        wait_for(1'b0, 1400, "t3 second new tick", t1);
        check("t3 new tick16 period", t1 - t0, 1302);

        // Request 19200 with both units idle: DRAIN 1 cycle, LOAD 1 cycle
        request(2'b11);
        check("t2 drain", int'(switching), 1);
        check("t2 rate during drain", int'(active_rate), 0);
        @(negedge clock);
        ld = cyc;
        check("t2 load", int'(switching), 1);
        @(negedge clock);
        check("t2 run", int'(switching), 0);
        check("t2 new rate", int'(active_rate), 3);
        wait_for(1'b0, 200, "t2 first tick", t0);
        check("t2 first tick after load", t0 - ld, 163);
        wait_for(1'b0, 200, "t2 second tick", t1);
        check("t2 tick16 period", t1 - t0, 163);

        // Same-rate request still runs the sequence and restarts the phase
        repeat (57) @(negedge clock);
        request(2'b11);
        check("t5 drain", int'(switching), 1);
        @(negedge clock);
        ld = cyc;
        @(negedge clock);
        check("t5 rate", int'(active_rate), 3);
        wait_for(1'b0, 200, "t5 first tick", t0);
        check("t5 first tick after load", t0 - ld, 163);

        // cfg_valid held through DRAIN: no second capture until back in RUN
        tx_busy   = 1'b1;
        cfg_rate  = 2'b01;
        cfg_valid = 1'b1;
        @(negedge clock);
        cfg_rate = 2'b10;
        check("t4 cfg_ready in drain", int'(cfg_ready), 0);
        repeat (50) @(negedge clock);
        check("t4 cfg_ready held low", int'(cfg_ready), 0);
        check("t4 rate unchanged", int'(active_rate), 3);
        tx_busy = 1'b0;
        @(negedge clock);
        @(negedge clock);
        check("t4 first capture installed", int'(active_rate), 1);
        check("t4 ready in run", int'(cfg_ready), 1);
        @(negedge clock);
        cfg_valid = 1'b0;
        check("t4 second request accepted", int'(switching), 1);
        @(negedge clock);
        @(negedge clock);
        check("t4 second capture installed", int'(active_rate), 2);

`ifdef BAUD_CTRL_TIMEOUT_EN
        // rx_busy stuck: forced LOAD after TB_TO bit_ticks, timeout sticky
        rx_busy = 1'b1;
        request(2'b11);
        nb = 0;
        done = 1'b0;
        for (int i = 0; i < (TB_TO + 1) * 5216 + 100; i++) begin
            if (bit_tick) nb++;
            if (!switching) begin
                done = 1'b1;
                break;
            end
            @(negedge clock);
        end
        check("to drain ended", int'(done), 1);
        check("to bit_ticks in drain", nb, TB_TO);
        check("to flag", int'(timeout), 1);
        check("to rate installed", int'(active_rate), 3);
        repeat (20) @(negedge clock);
        check("to flag sticky", int'(timeout), 1);
        rx_busy = 1'b0;
`endif

        // Reset mid-DRAIN drops the pending request
        rx_busy = 1'b1;
        request(2'b00);
        repeat (5) @(negedge clock);
        check("t6 draining", int'(switching), 1);
        #2 reset = 1'b1;
        @(negedge clock);
        check("t6 reset rate", int'(active_rate), 2);
        check("t6 reset switching", int'(switching), 0);
        check("t6 reset timeout", int'(timeout), 0);
        #2 reset = 1'b0;
        rx_busy = 1'b0;
        repeat (10) @(negedge clock);
        check("t6 request dropped", int'(active_rate), 2);
        check("t6 still run", int'(switching), 0);
        check("t6 ready", int'(cfg_ready), 1);

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/baud_ctrl.md
BAUD_CTRL -- requirements
Module: baud_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 11, giving the width of the 16x divider counter.
REQ-002 SHALL have parameter RESET_RATE, default 2'b10, giving the rate code loaded at reset (9600 baud).
REQ-003 SHALL have parameter TIMEOUT_BITS, default 32, giving the drain timeout in bit periods (used only with BAUD_CTRL_TIMEOUT_EN).
REQ-004 SHALL have port clock, input, 1 bit: the single system clock (50 MHz); all logic is on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port cfg_valid, input, 1 bit: rate-change request valid.
REQ-007 SHALL have port cfg_rate, input, 2 bits: requested rate code (00=2400, 01=4800, 10=9600, 11=19200).
REQ-008 SHALL have port cfg_ready, output, 1 bit: request accepted on the cycle where cfg_valid and cfg_ready are both high.
REQ-009 SHALL have ports tx_busy and rx_busy, input, 1 bit each: the serial units are mid-frame.
REQ-010 SHALL have port tick16, output, 1 bit: one-cycle pulse at 16x the active baud rate.
REQ-011 SHALL have port bit_tick, output, 1 bit: one-cycle pulse coincident with every 16th tick16.
REQ-012 SHALL have port active_rate, output, 2 bits: the rate code currently in use.
REQ-013 SHALL have port switching, output, 1 bit: high while the FSM is not in RUN.
REQ-014 SHALL have port timeout, output, 1 bit: sticky flag set when a drain was forced.

Function
REQ-015 SHALL implement FSM states RUN, DRAIN and LOAD.
REQ-016 SHALL drive cfg_ready high only in RUN; on handshake, SHALL capture cfg_rate into pending_rate and go to DRAIN.
REQ-017 SHALL accept a request for the rate already active; the full DRAIN/LOAD sequence runs and restarts the phase.
REQ-018 SHALL, in DRAIN, keep generating ticks at the old rate and move to LOAD on the first cycle where tx_busy and rx_busy are both low.
REQ-019 SHALL, in LOAD, last exactly one cycle: active_rate <= pending_rate, divider and phase counters <= 0, tick16 and bit_tick held low; next state is RUN.
REQ-020 SHALL pulse tick16 when div_cnt == DIV[active_rate]-1, with div_cnt wrapping to 0 on the same edge; tick period is exactly DIV cycles.
REQ-021 SHALL use the divisor table DIV = {1302, 651, 326, 163} for codes 00..11.
REQ-022 SHALL advance a 4-bit phase counter on each tick16 and pulse bit_tick when the phase wraps from 15 to 0.
REQ-023 SHALL ignore cfg_valid while not in RUN (request held by the requester, not lost).
REQ-024 SHALL keep the divider counter comparison CNT_W bits wide with no overflow for any table entry.

Reset
REQ-025 SHALL, on reset assertion, immediately force state RUN, active_rate RESET_RATE, pending_rate RESET_RATE, counters 0, tick16 0, bit_tick 0, timeout 0, switching 0, cfg_ready 1 after release.
REQ-026 SHALL, on reset mid-DRAIN, discard the pending request.

Configuration
REQ-027 SHALL, with BAUD_CTRL_TIMEOUT_EN defined, count bit_ticks in DRAIN, force LOAD after TIMEOUT_BITS of them regardless of busy inputs, and set timeout (cleared only by reset).
REQ-028 SHALL, without BAUD_CTRL_TIMEOUT_EN, wait in DRAIN indefinitely and tie timeout to 0.

Structure
REQ-029 SHALL place rate codes, the DIV table and the FSM state encoding in shared package baud_pkg.
REQ-030 SHALL implement the divider/phase counter as sub-module baud_tick_gen (inputs: div value, clear; outputs: tick16, bit_tick).

Verification
REQ-031 SHALL verify reset release with RESET_RATE=10 -> tick16 every 326 cycles, bit_tick every 5216 cycles.
REQ-032 SHALL verify a request for 11 with both busy inputs low -> DRAIN 1 cycle, LOAD 1 cycle, then tick16 period 163 and first tick16 163 cycles after LOAD.
REQ-033 SHALL verify a request for 00 with tx_busy high for 4000 cycles -> ticks continue at period 326 until busy falls, then period 1302.
REQ-034 SHALL verify cfg_valid held during DRAIN -> cfg_ready low and no second capture; the request is accepted on return to RUN.
REQ-035 SHALL verify, with BAUD_CTRL_TIMEOUT_EN, rx_busy stuck high -> LOAD after 32 bit_ticks and timeout=1 until reset.
REQ-036 SHALL verify reset asserted mid-DRAIN -> active_rate=RESET_RATE, state RUN, pending request dropped.
